dmem_lsu: RTL

Load/store unit between the single-cycle RISC-V core's memory stage and the word-organised data RAM (20-bit word address, 32-bit data, asynchronous read, write on `clk` qualified by `tick`). It converts RV32I byte/halfword/word loads and stores into whole-word RAM accesses. Stores use read-modify-write because the RAM has no byte enables. It raises `stall` to freeze the core's PC while an access is in flight, and flags misaligned or out-of-range accesses instead of touching memory.

---
 rtl/dmem_lsu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: maps RV32I b/h/w loads and stores onto a word-wide RAM with no byte enables.
// Latency: load 2 stall cycles, store 3 (read-modify-write), fault 1; result is valid in DONE.
// Backpressure: stall = req while not in DONE; the core holds req/inputs until stall falls.
module dmem_lsu #(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          wr,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          fault,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_d,
    output logic          ram_we,
    output logic          ram_tick,
    input  logic [31:0]   ram_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_wr;
    logic [2:0]  lat_f3;
    logic [31:0] old_word;

    logic        bad_f3;
    logic        bad_range;
    logic        bad_align;
    logic        req_fault;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] st_word;

    // Error classification of the incoming request; evaluated only at acceptance.
    always_comb begin
        bad_f3    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                    (wr && funct3[2]);
        bad_range = |addr[31:AW+2];
        bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_fault = bad_f3 || bad_range || bad_align;
    end

    // Lane select and sign/zero extension for loads (little-endian lanes).
    always_comb begin
        ld_byte = ram_q[{lat_addr[1:0], 3'b000} +: 8];
        ld_half = lat_addr[1] ? ram_q[31:16] : ram_q[15:0];
        case (lat_f3[1:0])
            2'b00:   ld_val = {{24{ld_byte[7] & ~lat_f3[2]}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~lat_f3[2]}}, ld_half};
            default: ld_val = ram_q;
        endcase
    end

    // Store merge: replace only the addressed lane of the word read in RD.
    always_comb begin
        st_word = old_word;
        case (lat_f3[1:0])
            2'b00:   st_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   st_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: st_word = lat_wdata;
        endcase
    end

    // RAM side and stall; a reset during WR suppresses the write in that same cycle.
    always_comb begin
        ram_addr = lat_addr[AW+1:2];
        ram_we   = (state == S_WR) && !rst;
        ram_tick = ram_we;
        ram_d    = ram_we ? st_word : 32'h0;
        stall    = req && (state != S_DONE);
    end

    // Access sequencer: latch on acceptance, read, optionally write back, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_wr    <= 1'b0;
            lat_f3    <= 3'b000;
            old_word  <= 32'h0;
            rdata     <= 32'h0;
            fault     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_wr    <= wr;
                        lat_f3    <= funct3;
                        rdata     <= 32'h0;
                        if (req_fault) begin
                            fault <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            fault <= 1'b0;
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (lat_wr) begin
                        old_word <= ram_q;
                        state    <= S_WR;
                    end else begin
                        rdata <= ld_val;
                        state <= S_DONE;
                    end
                end
                S_WR:    state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
